// File: rtl/tb_fetch_ctrl.sv
// Fetch controller: walks a 2D tile in SRAM line by line and streams each line, with lane mask and end-of-row flag, to the transpose buffer.
// Latency: first sram_ren one cycle after start is sampled; a line reaches tb_valid two cycles after its sram_ren; one line per cycle sustained.
// Backpressure: tb_ready low holds the 2-entry skid FIFO head stable; reads pause while FIFO occupancy plus the in-flight read would exceed two.
//
// Ports: clk/rst (async active-high); cfg_* tile description latched on an accepted start;
//        sram_ren/sram_addr/sram_rdata line-read port (1-cycle read latency);
//        tb_valid/tb_ready/tb_data/tb_valid_mask/tb_row_last stream to the transpose buffer;
//        busy while a tile is in progress, done one-cycle completion pulse.

// Small generic FIFO; head entry is presented combinationally from storage.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module tb_fetch_ctrl #(
    parameter int FETCH_WIDTH = 4,
    parameter int WORD_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ADDR_WIDTH-1:0]             cfg_start_addr,
    input  logic [7:0]                        cfg_row_len,
    input  logic [7:0]                        cfg_num_rows,
    input  logic [ADDR_WIDTH-1:0]             cfg_row_stride,
    input  logic                              start,
    output logic                              sram_ren,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    input  logic [FETCH_WIDTH*WORD_WIDTH-1:0] sram_rdata,
    output logic                              tb_valid,
    input  logic                              tb_ready,
    output logic [FETCH_WIDTH*WORD_WIDTH-1:0] tb_data,
    output logic [FETCH_WIDTH-1:0]            tb_valid_mask,
    output logic                              tb_row_last,
    output logic                              busy,
    output logic                              done
);
    localparam int LINE_W = FETCH_WIDTH * WORD_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [LINE_W-1:0]      dat;
        logic [FETCH_WIDTH-1:0] mask;
        logic                   last;
    } entry_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  stride_q, row_base_q, addr_q;
    logic [7:0]             rows_q, fpr_q, rem_q, fetch_idx_q, row_cnt_q;
    logic [7:0]             fpr_d, rem_d;
    logic                   last_fetch, last_row;
    logic [FETCH_WIDTH-1:0] issue_mask;
    logic                   rd_vld_q;
    logic [FETCH_WIDTH-1:0] rd_mask_q;
    logic                   rd_last_q;
    logic [1:0]             fifo_cnt;
    entry_t                 push_ent, head_ent;
    logic                   tb_pop;
    logic [2:0]             held_nxt;

    // Fetches per row (ceil) and words in the final fetch of a row.
    assign fpr_d = 8'((int'(cfg_row_len) + FETCH_WIDTH - 1) / FETCH_WIDTH);
    assign rem_d = 8'(int'(cfg_row_len) % FETCH_WIDTH);

    assign last_fetch = (fetch_idx_q == fpr_q - 8'd1);
    assign last_row   = (row_cnt_q == rows_q - 8'd1);

    always_comb begin
        issue_mask = '1;
        if (last_fetch && (rem_q != 8'd0)) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                issue_mask[i] = (i < int'(rem_q));
            end
        end
    end

    assign tb_pop = tb_valid & tb_ready;

    // Lines still to be held once this cycle's pop retires: counting the pop
    // keeps one line per cycle under tb_ready=1 while never exceeding two slots.
    assign held_nxt = 3'(fifo_cnt) + 3'(rd_vld_q) - 3'(tb_pop);

    always_comb begin
        state_d  = state_q;
        sram_ren = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((cfg_row_len == 8'd0) || (cfg_num_rows == 8'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (held_nxt < 3'd2) begin
                    sram_ren = 1'b1;
                    if (last_fetch && last_row) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final entry transfers so done lands the next cycle.
                if (!rd_vld_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && tb_pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tile walk: config latched at start, address advanced incrementally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q    <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            rows_q      <= '0;
            fpr_q       <= '0;
            rem_q       <= '0;
            fetch_idx_q <= '0;
            row_cnt_q   <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stride_q    <= cfg_row_stride;
            row_base_q  <= cfg_start_addr;
            addr_q      <= cfg_start_addr;
            rows_q      <= cfg_num_rows;
            fpr_q       <= fpr_d;
            rem_q       <= rem_d;
            fetch_idx_q <= '0;
            row_cnt_q   <= '0;
        end else if (sram_ren) begin
            if (last_fetch) begin
                fetch_idx_q <= '0;
                row_cnt_q   <= row_cnt_q + 8'd1;
                row_base_q  <= row_base_q + stride_q;
                addr_q      <= row_base_q + stride_q;
            end else begin
                fetch_idx_q <= fetch_idx_q + 8'd1;
                addr_q      <= addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Sideband travels with the read; clearing rd_vld_q on reset drops any
    // data still returning from before the reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_mask_q <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q <= sram_ren;
            if (sram_ren) begin
                rd_mask_q <= issue_mask;
                rd_last_q <= last_fetch;
            end
        end
    end

    always_comb begin
        push_ent.dat  = sram_rdata;
        push_ent.mask = rd_mask_q;
        push_ent.last = rd_last_q;
    end

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (2)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_vld_q),
        .push_dat (push_ent),
        .pop      (tb_pop),
        .head_dat (head_ent),
        .count    (fifo_cnt)
    );

    assign sram_addr     = sram_ren ? addr_q : '0;
    assign tb_valid      = (fifo_cnt != 2'd0);
    assign tb_data       = head_ent.dat;
    assign tb_valid_mask = head_ent.mask;
    assign tb_row_last   = head_ent.last;
    assign busy          = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_tb_fetch_ctrl.sv
// Bench for tb_fetch_ctrl: SRAM model, passive monitor and per-scenario tasks checked against a tile model.
// Latency: expects first read 1 cycle after start, data 2 cycles after read, done 1 cycle after last transfer.
// Backpressure: drives tb_ready held low, held high and randomized.
module tb_tb_fetch_ctrl;
    localparam int FW = 4;
    localparam int WW = 16;
    localparam int AW = 8;
    localparam int LW = FW * WW;

    typedef struct packed {
        logic [LW-1:0] dat;
        logic [FW-1:0] mask;
        logic          last;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cfg_start_addr;
    logic [7:0]    cfg_row_len;
    logic [7:0]    cfg_num_rows;
    logic [AW-1:0] cfg_row_stride;
    logic          start;
    logic          sram_ren;
    logic [AW-1:0] sram_addr;
    logic [LW-1:0] sram_rdata = '0;
    logic          tb_valid;
    logic          tb_ready;
    logic [LW-1:0] tb_data;
    logic [FW-1:0] tb_valid_mask;
    logic          tb_row_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tb_fetch_ctrl #(.FETCH_WIDTH(FW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start_addr (cfg_start_addr),
        .cfg_row_len    (cfg_row_len),
        .cfg_num_rows   (cfg_num_rows),
        .cfg_row_stride (cfg_row_stride),
        .start          (start),
        .sram_ren       (sram_ren),
        .sram_addr      (sram_addr),
        .sram_rdata     (sram_rdata),
        .tb_valid       (tb_valid),
        .tb_ready       (tb_ready),
        .tb_data        (tb_data),
        .tb_valid_mask  (tb_valid_mask),
        .tb_row_last    (tb_row_last),
        .busy           (busy),
        .done           (done)
    );

    // SRAM contents and 1-cycle read latency.
    logic [LW-1:0] mem [256];
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= mem[sram_addr];
    end

    // Passive monitor: logs reads, transfers, done pulses and protocol breaches.
    int            cyc = 0;
    int            held = 0;
    int            held_over = 0;
    int            stall_viol = 0;
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    xfer_t         pxf;
    xfer_t         head;
    int            ren_cyc_q[$];
    logic [AW-1:0] ren_addr_q[$];
    xfer_t         xfer_q[$];
    int            xfer_cyc_q[$];
    int            done_cyc_q[$];
    int            start_cyc_q[$];

    assign head = {tb_data, tb_valid_mask, tb_row_last};

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            held = 0;
            pv   = 1'b0;
        end else begin
            if (start) start_cyc_q.push_back(cyc);
            if (sram_ren) begin
                ren_cyc_q.push_back(cyc);
                ren_addr_q.push_back(sram_addr);
            end
            if (tb_valid && tb_ready) begin
                xfer_q.push_back(head);
                xfer_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
            if (pv && !pr && (!tb_valid || head !== pxf)) stall_viol++;
            held = held + (sram_ren ? 1 : 0) - ((tb_valid && tb_ready) ? 1 : 0);
            if (held > 2) held_over++;
            pv  = tb_valid;
            pr  = tb_ready;
            pxf = head;
        end
    end

    // Reference tile: address/mask/row_last straight from the tile definition.
    logic [AW-1:0] exp_addr[$];
    xfer_t         exp_x[$];

    function automatic void model_tile(input int sa, input int len, input int rows, input int sd);
        int fpr;
        int rem;
        logic [AW-1:0] a;
        xfer_t x;
        exp_addr.delete();
        exp_x.delete();
        fpr = (len + FW - 1) / FW;
        rem = len % FW;
        for (int r = 0; r < rows; r++) begin
            for (int f = 0; f < fpr; f++) begin
                a      = AW'((sa + r * sd + f) % (1 << AW));
                x.dat  = mem[a];
                x.last = (f == fpr - 1);
                x.mask = (x.last && rem != 0) ? FW'((1 << rem) - 1) : FW'((1 << FW) - 1);
                exp_addr.push_back(a);
                exp_x.push_back(x);
            end
        end
    endfunction

    task automatic pulse_start(input int sa, input int len, input int rows, input int sd);
        @(posedge clk); #1;
        cfg_start_addr = AW'(sa);
        cfg_row_len    = 8'(len);
        cfg_num_rows   = 8'(rows);
        cfg_row_stride = AW'(sd);
        start          = 1'b1;
        @(posedge clk); #1;
        start          = 1'b0;
        // Scramble config: the running tile must not follow it.
        cfg_start_addr = AW'($urandom);
        cfg_row_len    = 8'($urandom);
        cfg_num_rows   = 8'($urandom);
        cfg_row_stride = AW'($urandom);
    endtask

    task automatic wait_done(input int base, input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) tb_ready = ($urandom_range(0, 3) != 0);
            if (done_cyc_q.size() > base) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({sram_ren, tb_valid, tb_data, tb_valid_mask, tb_row_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset.outputs: got ren=%b vld=%b dat=%h msk=%h last=%b busy=%b done=%b, want all 0",
                     sram_ren, tb_valid, tb_data, tb_valid_mask, tb_row_last, busy, done);
        end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({sram_ren, tb_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset.idle: got ren=%b vld=%b busy=%b done=%b, want 0000", sram_ren, tb_valid, busy, done);
        end
    endtask

    task automatic test_full_lines();
        int rb, xb, db, s;
        bit ok;
        tb_ready = 1'b1;
        rb = ren_cyc_q.size(); xb = xfer_q.size(); db = done_cyc_q.size();
        model_tile(8'h10, 8, 2, 4);
        pulse_start(8'h10, 8, 2, 4);
        s = start_cyc_q[start_cyc_q.size() - 1];
        wait_done(db, 200, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full.timeout: done not seen in 200 cycles"); end
        checks++;
        if (ren_cyc_q.size() - rb !== 4) begin
            errors++; $display("FAIL full.ren_count: got %0d want 4", ren_cyc_q.size() - rb);
        end
        for (int i = 0; i < exp_addr.size() && rb + i < ren_cyc_q.size(); i++) begin
            checks++;
            if (ren_addr_q[rb + i] !== exp_addr[i] || ren_cyc_q[rb + i] !== s + 1 + i) begin
                errors++;
                $display("FAIL full.ren[%0d]: got addr %h cyc %0d want addr %h cyc %0d",
                         i, ren_addr_q[rb + i], ren_cyc_q[rb + i], exp_addr[i], s + 1 + i);
            end
        end
        for (int i = 0; i < exp_x.size() && xb + i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[xb + i] !== exp_x[i] || xfer_cyc_q[xb + i] !== s + 3 + i) begin
                errors++;
                $display("FAIL full.xfer[%0d]: got %h cyc %0d want %h cyc %0d",
                         i, xfer_q[xb + i], xfer_cyc_q[xb + i], exp_x[i], s + 3 + i);
            end
        end
        checks++;
        if (done_cyc_q.size() - db !== 1 || done_cyc_q[db] !== s + 7) begin
            errors++;
            $display("FAIL full.done: got %0d pulses first cyc %0d want 1 pulse cyc %0d",
                     done_cyc_q.size() - db, (done_cyc_q.size() > db) ? done_cyc_q[db] : -1, s + 7);
        end
    endtask

    task automatic test_partial_fetch();
        int xb, db, rb;
        bit ok;
        tb_ready = 1'b1;
        rb = ren_cyc_q.size(); xb = xfer_q.size(); db = done_cyc_q.size();
        model_tile(0, 6, 3, 2);
        pulse_start(0, 6, 3, 2);
        wait_done(db, 200, 1'b0, ok);
        checks++;
        if (!ok || xfer_q.size() - xb !== 6) begin
            errors++; $display("FAIL partial.count: got %0d transfers done=%b want 6 and done", xfer_q.size() - xb, ok);
        end
        for (int i = 0; i < exp_x.size() && xb + i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[xb + i] !== exp_x[i] || ren_addr_q[rb + i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL partial.xfer[%0d]: got %h addr %h want %h addr %h",
                         i, xfer_q[xb + i], ren_addr_q[rb + i], exp_x[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int rb, xb, db, s, v, sv, ho, stalled_ren;
        bit ok;
        tb_ready = 1'b0;
        rb = ren_cyc_q.size(); xb = xfer_q.size(); db = done_cyc_q.size();
        sv = stall_viol; ho = held_over;
        model_tile(8'h80, 16, 1, 0);
        pulse_start(8'h80, 16, 1, 0);
        s = start_cyc_q[start_cyc_q.size() - 1];
        v = -1;
        for (int i = 0; i < 50; i++) begin
            if (tb_valid) begin v = cyc + 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (v !== s + 3) begin errors++; $display("FAIL bp.first_valid: got cyc %0d want %0d", v, s + 3); end
        repeat (6) begin @(posedge clk); #1; end
        tb_ready = 1'b1;
        wait_done(db, 200, 1'b0, ok);
        stalled_ren = 0;
        for (int i = rb; i < ren_cyc_q.size(); i++) begin
            if (ren_cyc_q[i] >= v && ren_cyc_q[i] <= v + 5) stalled_ren++;
        end
        checks++;
        if (stalled_ren !== 0) begin errors++; $display("FAIL bp.ren_stalled: got %0d reads during stall want 0", stalled_ren); end
        checks++;
        if (held_over - ho !== 0) begin errors++; $display("FAIL bp.outstanding: got %0d cycles over 2 held want 0", held_over - ho); end
        checks++;
        if (stall_viol - sv !== 0) begin errors++; $display("FAIL bp.stable: got %0d unstable stall cycles want 0", stall_viol - sv); end
        checks++;
        if (!ok || xfer_q.size() - xb !== 4) begin
            errors++; $display("FAIL bp.count: got %0d transfers done=%b want 4 and done", xfer_q.size() - xb, ok);
        end
        for (int i = 0; i < exp_x.size() && xb + i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[xb + i] !== exp_x[i]) begin
                errors++; $display("FAIL bp.xfer[%0d]: got %h want %h", i, xfer_q[xb + i], exp_x[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        int rb, xb, db, s;
        bit ok;
        tb_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rb = ren_cyc_q.size(); xb = xfer_q.size(); db = done_cyc_q.size();
            if (k == 0) pulse_start(8'h20, 0, 5, 1);
            else        pulse_start(8'h20, 8, 0, 1);
            s = start_cyc_q[start_cyc_q.size() - 1];
            wait_done(db, 50, 1'b0, ok);
            checks++;
            if (!ok || done_cyc_q[db] !== s + 1 || done_cyc_q.size() - db !== 1) begin
                errors++;
                $display("FAIL degen%0d.done: got %0d pulses first cyc %0d want 1 pulse cyc %0d",
                         k, done_cyc_q.size() - db, ok ? done_cyc_q[db] : -1, s + 1);
            end
            checks++;
            if (ren_cyc_q.size() - rb !== 0 || xfer_q.size() - xb !== 0) begin
                errors++;
                $display("FAIL degen%0d.activity: got %0d reads %0d transfers want 0 0", k, ren_cyc_q.size() - rb, xfer_q.size() - xb);
            end
        end
    endtask

    task automatic test_wrap_ignored_start();
        int rb, db, s;
        bit ok;
        tb_ready = 1'b1;
        rb = ren_cyc_q.size(); db = done_cyc_q.size();
        model_tile(8'hFE, 12, 1, 3);
        pulse_start(8'hFE, 12, 1, 3);
        s = start_cyc_q[start_cyc_q.size() - 1];
        pulse_start(8'h40, 4, 2, 1);                  // lands while busy
        while (cyc + 1 < s + 6) begin @(posedge clk); #1; end
        cfg_start_addr = 8'h50; cfg_row_len = 8'd4; cfg_num_rows = 8'd1;
        start = 1'b1;                                  // lands in the DONE cycle
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(db, 100, 1'b0, ok);
        checks++;
        if (ren_cyc_q.size() - rb !== 3) begin
            errors++; $display("FAIL wrap.ren_count: got %0d want 3", ren_cyc_q.size() - rb);
        end
        for (int i = 0; i < 3 && rb + i < ren_addr_q.size(); i++) begin
            checks++;
            if (ren_addr_q[rb + i] !== exp_addr[i]) begin
                errors++; $display("FAIL wrap.addr[%0d]: got %h want %h", i, ren_addr_q[rb + i], exp_addr[i]);
            end
        end
        checks++;
        if (done_cyc_q.size() - db !== 1) begin
            errors++; $display("FAIL wrap.done_count: got %0d want 1", done_cyc_q.size() - db);
        end
    endtask

    task automatic test_reset_mid_tile();
        int rb, xb, db;
        bit ok;
        tb_ready = 1'b1;
        xb = xfer_q.size();
        pulse_start(8'h30, 32, 1, 0);
        for (int i = 0; i < 100 && xfer_q.size() - xb < 2; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if (xfer_q.size() - xb !== 2) begin errors++; $display("FAIL rstmid.before: got %0d transfers want 2", xfer_q.size() - xb); end
        checks++;
        if ({sram_ren, tb_valid, tb_data, tb_valid_mask, tb_row_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rstmid.outputs: got ren=%b vld=%b dat=%h msk=%h last=%b busy=%b done=%b, want all 0",
                     sram_ren, tb_valid, tb_data, tb_valid_mask, tb_row_last, busy, done);
        end
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        rb = ren_cyc_q.size(); xb = xfer_q.size(); db = done_cyc_q.size();
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0 || ren_cyc_q.size() - rb !== 0 || xfer_q.size() - xb !== 0 || done_cyc_q.size() - db !== 0) begin
            errors++;
            $display("FAIL rstmid.idle: got busy=%b reads=%0d transfers=%0d dones=%0d want all 0",
                     busy, ren_cyc_q.size() - rb, xfer_q.size() - xb, done_cyc_q.size() - db);
        end
        model_tile(8'h30, 32, 1, 0);
        pulse_start(8'h30, 32, 1, 0);
        wait_done(db, 200, 1'b0, ok);
        checks++;
        if (!ok || xfer_q.size() - xb !== 8 || done_cyc_q.size() - db !== 1) begin
            errors++;
            $display("FAIL rstmid.rerun: got %0d transfers %0d dones want 8 1", xfer_q.size() - xb, done_cyc_q.size() - db);
        end
        for (int i = 0; i < exp_x.size() && xb + i < xfer_q.size(); i++) begin
            checks++;
            if (xfer_q[xb + i] !== exp_x[i]) begin
                errors++; $display("FAIL rstmid.xfer[%0d]: got %h want %h", i, xfer_q[xb + i], exp_x[i]);
            end
        end
    endtask

    task automatic test_random();
        int rb, xb, db, s, sv, ho, sa, len, rows, sd, want_done;
        bit ok;
        for (int t = 0; t < 10; t++) begin
            sa = $urandom_range(0, 255); len = $urandom_range(0, 40);
            rows = $urandom_range(0, 4); sd = $urandom_range(0, 255);
            rb = ren_cyc_q.size(); xb = xfer_q.size(); db = done_cyc_q.size();
            sv = stall_viol; ho = held_over;
            model_tile(sa, len, rows, sd);
            pulse_start(sa, len, rows, sd);
            s = start_cyc_q[start_cyc_q.size() - 1];
            wait_done(db, 2000, 1'b1, ok);
            tb_ready = 1'b1;
            checks++;
            if (!ok || ren_cyc_q.size() - rb !== exp_addr.size() || xfer_q.size() - xb !== exp_x.size()) begin
                errors++;
                $display("FAIL rand%0d.count: got %0d reads %0d transfers done=%b want %0d %0d and done (sa=%0d len=%0d rows=%0d sd=%0d)",
                         t, ren_cyc_q.size() - rb, xfer_q.size() - xb, ok, exp_addr.size(), exp_x.size(), sa, len, rows, sd);
            end
            for (int i = 0; i < exp_x.size() && xb + i < xfer_q.size() && rb + i < ren_addr_q.size(); i++) begin
                checks++;
                if (xfer_q[xb + i] !== exp_x[i] || ren_addr_q[rb + i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL rand%0d.xfer[%0d]: got %h addr %h want %h addr %h",
                             t, i, xfer_q[xb + i], ren_addr_q[rb + i], exp_x[i], exp_addr[i]);
                end
            end
            want_done = (exp_x.size() == 0 || xfer_q.size() - xb == 0) ? s + 1 : xfer_cyc_q[xfer_q.size() - 1] + 1;
            checks++;
            if (done_cyc_q.size() - db !== 1 || done_cyc_q[db] !== want_done) begin
                errors++;
                $display("FAIL rand%0d.done: got %0d pulses first cyc %0d want 1 pulse cyc %0d",
                         t, done_cyc_q.size() - db, (done_cyc_q.size() > db) ? done_cyc_q[db] : -1, want_done);
            end
            checks++;
            if (stall_viol - sv !== 0 || held_over - ho !== 0) begin
                errors++;
                $display("FAIL rand%0d.protocol: got %0d unstable stalls %0d over-held cycles want 0 0", t, stall_viol - sv, held_over - ho);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tb_ready = 1'b0;
        cfg_start_addr = '0; cfg_row_len = '0; cfg_num_rows = '0; cfg_row_stride = '0;
        for (int i = 0; i < 256; i++) mem[i] = LW'({$urandom, $urandom});
        test_reset();
        test_full_lines();
        test_partial_fetch();
        test_backpressure();
        test_degenerate();
        test_wrap_ignored_start();
        test_reset_mid_tile();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tb_fetch_ctrl.md
Name: tb_fetch_ctrl

Overview:
Fetch controller sitting directly upstream of transpose_buffer. Walks a 2D tile in SRAM: rows of cfg_row_len words, FETCH_WIDTH words per SRAM line. Issues SRAM line reads and delivers each returned line to the transpose buffer with a per-lane valid mask and an end-of-row flag. Absorbs the 1-cycle SRAM read latency and transpose-buffer backpressure with a 2-entry skid FIFO, so no data is lost or reordered.

Parameters:
FETCH_WIDTH, 4, words per SRAM line / lanes to transpose buffer
WORD_WIDTH, 16, bits per word
ADDR_WIDTH, 8, SRAM line-address width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset; clears all state immediately
cfg_start_addr  input  ADDR_WIDTH  line address of row 0, fetch 0
cfg_row_len  input  8  words per row (0..255)
cfg_num_rows  input  8  rows in tile (0..255)
cfg_row_stride  input  ADDR_WIDTH  line-address increment between rows
start  input  1  launch pulse; sampled only in IDLE
sram_ren  output  1  SRAM read enable
sram_addr  output  ADDR_WIDTH  SRAM line address, valid when sram_ren=1
sram_rdata  input  FETCH_WIDTH*WORD_WIDTH  read data, valid the cycle after sram_ren
tb_valid  output  1  FIFO head valid
tb_ready  input  1  transpose buffer accepts
tb_data  output  FETCH_WIDTH*WORD_WIDTH  line data; lane i = bits [i*WORD_WIDTH +: WORD_WIDTH]
tb_valid_mask  output  FETCH_WIDTH  per-lane valid (drives transpose buffer valid_input)
tb_row_last  output  1  head entry is the last fetch of its row
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; counters 0. Reset mid-operation aborts the tile. Read data returning after reset is discarded.
- Config is latched when start is accepted. Later config changes do not affect the running tile.
- fetches_per_row = ceil(cfg_row_len / FETCH_WIDTH); rem = cfg_row_len mod FETCH_WIDTH.
- Mask: all ones, except the last fetch of a row when rem != 0. In that case lanes [rem-1:0] are 1 and the rest are 0 (e.g. rem=2 -> 4'b0011).
- Address = start + row*stride + fetch_idx, computed incrementally. Arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
- Mask and row_last are computed at issue time and carried alongside the in-flight read into the FIFO.
- States:
  - IDLE: busy=0.
    - start=1 with cfg_row_len=0 or cfg_num_rows=0 -> DONE; no reads issued.
    - start=1 otherwise -> FETCH.
  - FETCH: busy=1. Assert sram_ren when (FIFO occupancy + in-flight read) < 2. After the final read is issued -> DRAIN.
  - DRAIN: busy=1, no reads. When the FIFO is empty, no read is in flight and the final entry has been accepted -> DONE.
  - DONE: done=1, busy=0 for exactly one cycle -> IDLE.
- Timing:
  - First sram_ren is in the cycle after start is sampled.
  - Data is written into the FIFO at the end of the cycle after sram_ren, so tb_valid is 2 cycles after sram_ren.
  - With tb_ready held at 1, throughput is 1 line per cycle.
- Handshake:
  - Transfer occurs when tb_valid & tb_ready.
  - tb_data, tb_valid_mask and tb_row_last are stable while tb_valid=1 and tb_ready=0.
  - tb_valid never drops without a transfer.
- Simultaneous FIFO push and pop is allowed at any occupancy (occupancy unchanged).
- The issue gate guarantees the FIFO never overflows; overflow is unreachable by construction.
- start while busy, or in the DONE cycle, is ignored.
- The tile's final transfer happens in cycle T; done pulses in cycle T+1.

Test Plan:
- Full lines, no backpressure: start=0x10, row_len=8, rows=2, stride=4, tb_ready=1 -> sram_addr 0x10,0x11,0x14,0x15 on consecutive cycles; 4 transfers, all mask 4'hF; row_last on transfers 2 and 4; done one cycle after transfer 4.
- Partial last fetch: row_len=6, rows=3, stride=2, start=0 -> addrs 0,1,2,3,4,5; masks F,3,F,3,F,3; row_last on every second transfer.
- Backpressure: row_len=16, rows=1, tb_ready=0 for 6 cycles after the first tb_valid -> at most 2 reads outstanding/held; sram_ren low while stalled; output data stable; all 4 lines delivered in address order once tb_ready=1.
- Degenerate config: row_len=0, rows=5 -> sram_ren never asserted, tb_valid never asserted, done pulses the cycle after start.
- Wrap and ignored start: start=0xFE, row_len=12, rows=1, second start pulse while busy -> addrs 0xFE,0xFF,0x00 only; exactly one done pulse.
- Reset mid-tile: assert rst after 2 transfers of an 8-transfer tile -> outputs 0 immediately, FIFO empty; after release the block is IDLE; a new start runs a full tile correctly.
